// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream FIFO: pointer sizing, depth checks,
// registered flag bundle and the pointer type of the default configuration.
package axis_fifo_pkg;

  // Index bits plus one wrap bit, so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  localparam int  DEF_DEPTH    = 16;
  localparam bit  DEF_DEPTH_OK = is_pow2(DEF_DEPTH);

  typedef logic [ptr_w(DEF_DEPTH)-1:0] fifo_ptr_t;

  typedef struct packed {
    logic s_ready;
    logic m_valid;
    logic almost_full;
    logic empty;
  } fifo_flags_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_fifo_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // No reset on the array; the pointers alone define what is valid.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_str_fifo.sv
// First-word-fall-through AXI-Stream FIFO with registered handshake flags,
// fill level and almost-full watermark.
module axis_str_fifo
  import axis_fifo_pkg::*;
#(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      almost_full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  typedef logic [PW-1:0] ptr_t;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("axis_str_fifo: DEPTH must be a power of two >= 2");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("axis_str_fifo: ALMOST_FULL_LEVEL out of range 1..DEPTH");
  end

  ptr_t        wr_ptr, rd_ptr;
  ptr_t        fill_next;
  fifo_flags_t flags_next;
  logic        push, pop;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Flags are computed from the next occupancy so they register on the
  // same edge as the pointers; neither ready nor valid sees the other side combinationally.
  always_comb begin
    fill_next = fill_level;
    if (push && !pop)      fill_next = fill_level + ptr_t'(1);
    else if (pop && !push) fill_next = fill_level - ptr_t'(1);

    flags_next.s_ready     = (fill_next != ptr_t'(DEPTH));
    flags_next.m_valid     = (fill_next != '0);
    flags_next.almost_full = (fill_next >= ptr_t'(ALMOST_FULL_LEVEL));
    flags_next.empty       = (fill_next == '0);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      almost_full   <= 1'b0;
      empty         <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      fill_level    <= fill_next;
      s_axis_tready <= flags_next.s_ready;
      m_axis_tvalid <= flags_next.m_valid;
      almost_full   <= flags_next.almost_full;
      empty         <= flags_next.empty;
    end
  end

  axis_fifo_ram #(
    .W     (AXI_DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_axis_tdata)
  );

endmodule
